// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart -- full-duplex 8N1 UART transceiver
//
// One transmitter and one receiver share the system clock and a fixed bit
// period of CLKS_PER_BIT clocks (80 MHz / 694 is about 115200 baud). Frames
// are 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
//
// Parameters
//   CLKS_PER_BIT   system clocks per serial bit, 4 or more
//
// Ports
//   i_Clock        system clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_Start        transmit request, only looked at while busy = 0
//   i_Data[7:0]    byte to transmit, captured when i_Start is accepted
//   o_TX           serial output, idles high
//   i_RX           serial input, asynchronous to i_Clock, idles high
//   o_Received     one-cycle strobe, a freshly received byte is on o_Data
//   o_Data[7:0]    last correctly framed byte, held until the next one
//   busy           transmitter is sending a frame
//   sample_point   one-cycle debug strobe at every receiver sample instant
//
// Optional feature macro
//   UART_RX_SYNC_EN  when defined, i_RX goes through a two-flop synchroniser
//                    (reset value 1) ahead of the receiver, which adds two
//                    cycles to every receive timing. When undefined, i_RX
//                    feeds the receiver directly (pre-synchronised inputs).
// ---------------------------------------------------------------------------
module uart #(
   parameter int CLKS_PER_BIT = 694
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Start,
   input  logic [7:0] i_Data,
   output logic       o_TX,
   input  logic       i_RX,
   output logic       o_Received,
   output logic [7:0] o_Data,
   output logic       busy,
   output logic       sample_point
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT >> 1) - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } txState_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rxState_t;

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   txState_t         txState_q, txState_d;
   logic [CNT_W-1:0] txCnt_q, txCnt_d;
   logic [2:0]       txBit_q, txBit_d;
   logic [7:0]       txShift_q, txShift_d;
   logic             txOut_q, txOut_d;
   logic             busy_q, busy_d;
   logic             txBitEnd;

   assign txBitEnd = (txCnt_q == BIT_LAST);

   // Next-state logic for the transmitter. The shift register is consumed
   // LSB first, so the bit currently on the line is always txShift[0].
   // o_TX and busy are registered from the next state, which gives the
   // one-cycle start latency and makes busy fall exactly as the stop bit
   // ends.
   always_comb begin
      txState_d = txState_q;
      txCnt_d   = txCnt_q;
      txBit_d   = txBit_q;
      txShift_d = txShift_q;
      case (txState_q)
         TX_IDLE: begin
            txCnt_d = '0;
            if (i_Start) begin
               txShift_d = i_Data;
               txState_d = TX_START;
            end
         end
         TX_START: begin
            if (txBitEnd) begin
               txCnt_d   = '0;
               txBit_d   = 3'd0;
               txState_d = TX_DATA;
            end else begin
               txCnt_d = txCnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (txBitEnd) begin
               txCnt_d   = '0;
               txShift_d = {1'b0, txShift_q[7:1]};
               if (txBit_q == 3'd7) begin
                  txState_d = TX_STOP;
               end else begin
                  txBit_d = txBit_q + 3'd1;
               end
            end else begin
               txCnt_d = txCnt_q + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (txBitEnd) begin
               txCnt_d   = '0;
               txState_d = TX_IDLE;
            end else begin
               txCnt_d = txCnt_q + CNT_W'(1);
            end
         end
         default: begin
            txCnt_d   = '0;
            txState_d = TX_IDLE;
         end
      endcase

      case (txState_d)
         TX_START: txOut_d = 1'b0;
         TX_DATA:  txOut_d = txShift_d[0];
         default:  txOut_d = 1'b1;
      endcase
      busy_d = (txState_d != TX_IDLE);
   end

   // Transmitter registers; reset drops any frame in flight and parks the
   // line high.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         txState_q <= TX_IDLE;
         txCnt_q   <= '0;
         txBit_q   <= 3'd0;
         txShift_q <= 8'h00;
         txOut_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         txState_q <= txState_d;
         txCnt_q   <= txCnt_d;
         txBit_q   <= txBit_d;
         txShift_q <= txShift_d;
         txOut_q   <= txOut_d;
         busy_q    <= busy_d;
      end
   end

   assign o_TX = txOut_q;
   assign busy = busy_q;

   // ------------------------------------------------------------------
   // Receiver input path
   // ------------------------------------------------------------------
   logic rxIn;

`ifdef UART_RX_SYNC_EN
   logic [1:0] rxSync_q;

   // Two-flop synchroniser for the asynchronous serial input. It resets to
   // the idle level so that reset never looks like a start bit.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rxSync_q <= 2'b11;
      end else begin
         rxSync_q <= {rxSync_q[0], i_RX};
      end
   end

   assign rxIn = rxSync_q[1];
`else
   assign rxIn = i_RX;
`endif

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   rxState_t         rxState_q, rxState_d;
   logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
   logic [2:0]       rxBit_q, rxBit_d;
   logic [7:0]       rxShift_q, rxShift_d;
   logic             rxValid_q, rxValid_d;
   logic [7:0]       rxData_q, rxData_d;
   logic             rxSample;

   // Next-state logic for the receiver. The start bit is re-checked half a
   // bit after the falling edge, which centres every later sample in its
   // bit. The sample strobe depends only on state and counter, so it also
   // fires for the start check that rejects a glitch. After a good stop
   // sample we drop back to IDLE mid stop bit so that a back-to-back start
   // edge is not missed; after a bad one we wait for the line to go high.
   always_comb begin
      rxState_d = rxState_q;
      rxCnt_d   = rxCnt_q;
      rxBit_d   = rxBit_q;
      rxShift_d = rxShift_q;
      rxData_d  = rxData_q;
      rxValid_d = 1'b0;
      rxSample  = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            rxCnt_d = '0;
            if (!rxIn) begin
               rxState_d = RX_START;
            end
         end
         RX_START: begin
            if (rxCnt_q == HALF_LAST) begin
               rxSample  = 1'b1;
               rxCnt_d   = '0;
               rxBit_d   = 3'd0;
               rxState_d = rxIn ? RX_IDLE : RX_DATA;
            end else begin
               rxCnt_d = rxCnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (rxCnt_q == BIT_LAST) begin
               rxSample  = 1'b1;
               rxCnt_d   = '0;
               rxShift_d = {rxIn, rxShift_q[7:1]};
               if (rxBit_q == 3'd7) begin
                  rxState_d = RX_STOP;
               end else begin
                  rxBit_d = rxBit_q + 3'd1;
               end
            end else begin
               rxCnt_d = rxCnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (rxCnt_q == BIT_LAST) begin
               rxSample = 1'b1;
               rxCnt_d  = '0;
               if (rxIn) begin
                  rxValid_d = 1'b1;
                  rxData_d  = rxShift_q;
                  rxState_d = RX_IDLE;
               end else begin
                  rxState_d = RX_WAIT_IDLE;
               end
            end else begin
               rxCnt_d = rxCnt_q + CNT_W'(1);
            end
         end
         RX_WAIT_IDLE: begin
            rxCnt_d = '0;
            if (rxIn) begin
               rxState_d = RX_IDLE;
            end
         end
         default: begin
            rxCnt_d   = '0;
            rxState_d = RX_IDLE;
         end
      endcase
   end

   // Receiver registers; the received byte and its strobe are registered so
   // they appear together in the cycle after the stop sample.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rxState_q <= RX_IDLE;
         rxCnt_q   <= '0;
         rxBit_q   <= 3'd0;
         rxShift_q <= 8'h00;
         rxValid_q <= 1'b0;
         rxData_q  <= 8'h00;
      end else begin
         rxState_q <= rxState_d;
         rxCnt_q   <= rxCnt_d;
         rxBit_q   <= rxBit_d;
         rxShift_q <= rxShift_d;
         rxValid_q <= rxValid_d;
         rxData_q  <= rxData_d;
      end
   end

   assign o_Received   = rxValid_q;
   assign o_Data       = rxData_q;
   assign sample_point = rxSample;

endmodule

// File: tb/tb_uart.sv
// ---------------------------------------------------------------------------
// tb_uart -- self-checking bench for uart
//
// A short bit period keeps run time small. A frame-level model predicts the
// TX line and busy from the accepted byte and elapsed time, and predicts
// o_Received / o_Data / sample_point from the frames the bench itself sends.
// One compare process checks every output every cycle; directed scenarios
// add literal expectations.
// ---------------------------------------------------------------------------
module tb_uart;

   localparam int CPB  = 32;
   localparam int HALF = CPB >> 1;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] din;
   logic       rx;
   logic       oTx;
   logic       oRecv;
   logic [7:0] oData;
   logic       busy;
   logic       samplePoint;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   bit checkEn = 1'b0;

   // Frame-level model state
   bit         txActive = 1'b0;
   int         txElapsed = 0;
   logic [7:0] txByte = 8'h00;
   logic [7:0] modelData = 8'h00;

   typedef struct {
      int         when;
      logic [7:0] data;
   } rxEvent_t;

   rxEvent_t recvQ[$];
   int       spQ[$];

   // Observation monitors used by the directed scenarios
   logic [7:0] gotBytes[$];
   int         sampleCount = 0;
   int         busyRun = 0;
   int         lastBusyRun = 0;
   int         busyRises = 0;
   int         busyRiseCyc = -1;
   bit         busyPrev = 1'b0;

   uart #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock     (clock),
      .i_Reset     (reset),
      .i_Start     (start),
      .i_Data      (din),
      .o_TX        (oTx),
      .i_RX        (rx),
      .o_Received  (oRecv),
      .o_Data      (oData),
      .busy        (busy),
      .sample_point(samplePoint)
   );

   // 10 ns clock; cyc names the cycle that follows each rising edge
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Value on the serial line during bit idx of a frame carrying d
   function automatic logic frameBit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      else if (idx <= 8) return d[idx-1];
      else return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One-cycle transmit request
   task automatic applyStimulus(input logic [7:0] d);
      @(posedge clock);
      #1;
      start = 1'b1;
      din   = d;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic waitBusyIdle();
      for (int k = 0; k < 20 * CPB; k++) begin
         if (busy === 1'b0) break;
         @(posedge clock);
         #1;
      end
      checkOutput("busy_idle_wait", busy, 1'b0);
   endtask

   // Drive one serial frame with a bit period of CPB*pct/100 clocks and
   // record which receiver events it must produce.
   task automatic sendRxFrame(input logic [7:0] d, input logic stopVal, input int pct);
      logic [9:0] bits;
      int s;
      int tEnd;
      bits = {stopVal, d, 1'b0};
      @(posedge clock);
      #1;
      s  = cyc;
      rx = 1'b0;
      for (int k = 0; k < 10; k++) spQ.push_back(s + SYNC + HALF + k * CPB);
      if (stopVal) recvQ.push_back('{s + SYNC + HALF + 9 * CPB + 1, d});
      for (int i = 1; i <= 10; i++) begin
         tEnd = s + (i * CPB * pct + 50) / 100;
         while (cyc < tEnd) begin
            @(posedge clock);
            #1;
         end
         rx = (i < 10) ? bits[i] : 1'b1;
      end
   endtask

   // Compare every output against the model, then advance the model by
   // the inputs that the next rising edge will sample.
   always @(negedge clock) begin
      logic expTx;
      logic expRecv;
      logic expSp;
      if (checkEn) begin
         expTx = txActive ? frameBit(txByte, txElapsed / CPB) : 1'b1;
         checkOutput("busy", busy, txActive);
         checkOutput("o_TX", oTx, expTx);
         expRecv = (recvQ.size() > 0) && (recvQ[0].when == cyc);
         checkOutput("o_Received", oRecv, expRecv);
         if (expRecv) begin
            modelData = recvQ[0].data;
            void'(recvQ.pop_front());
         end
         checkOutput("o_Data", oData, modelData);
         expSp = (spQ.size() > 0) && (spQ[0] == cyc);
         checkOutput("sample_point", samplePoint, expSp);
         if (expSp) void'(spQ.pop_front());
      end
      if (reset) begin
         txActive  = 1'b0;
         txElapsed = 0;
         modelData = 8'h00;
         recvQ.delete();
         spQ.delete();
      end else if (txActive) begin
         txElapsed++;
         if (txElapsed == 10 * CPB) txActive = 1'b0;
      end else if (start) begin
         txActive  = 1'b1;
         txElapsed = 0;
         txByte    = din;
      end
   end

   // Record received bytes, sample strobes and busy run lengths
   always @(negedge clock) begin
      if (checkEn) begin
         if (oRecv === 1'b1) gotBytes.push_back(oData);
         if (samplePoint === 1'b1) sampleCount++;
         if (busy === 1'b1) begin
            if (!busyPrev) begin
               busyRises++;
               busyRiseCyc = cyc;
            end
            busyRun++;
         end else if (busyRun > 0) begin
            lastBusyRun = busyRun;
            busyRun = 0;
         end
         busyPrev = (busy === 1'b1);
      end
   end

   initial begin
      int s;
      int n0;
      int sc0;
      int r0;
      int recvCyc;
      int txFirst;
      logic [7:0] got;
      logic [9:0] expA5;
      bit seen;

      reset = 1'b1;
      start = 1'b0;
      din   = 8'h00;
      rx    = 1'b1;
      recvCyc = -1;

      // Reset held for one cycle
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_o_TX", oTx, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_o_Received", oRecv, 1'b0);
      checkOutput("reset_o_Data", oData, 8'h00);
      checkOutput("reset_sample_point", samplePoint, 1'b0);
      checkEn = 1'b1;

      // Transmit 0xA5: start, d0..d7, stop
      expA5 = 10'b11_0100_1010;
      applyStimulus(8'hA5);
      txFirst = cyc;
      for (int i = 0; i < 10; i++) begin
         while (cyc < txFirst + i * CPB + HALF) begin
            @(posedge clock);
            #1;
         end
         @(negedge clock);
         checkOutput($sformatf("tx_A5_bit%0d", i), oTx, expA5[i]);
      end
      waitBusyIdle();
      waitCycles(2);
      checkOutput("tx_A5_busy_len", lastBusyRun, 320);

      // Three back-to-back frames from a sender 1% fast
      n0 = gotBytes.size();
      sendRxFrame(8'h61, 1'b1, 99);
      sendRxFrame(8'h62, 1'b1, 99);
      sendRxFrame(8'h0A, 1'b1, 99);
      waitCycles(4);
      checkOutput("rx_trio_count", gotBytes.size() - n0, 3);
      got = 8'hxx;
      if (gotBytes.size() > n0) got = gotBytes[n0];
      checkOutput("rx_trio_byte0", got, 8'h61);
      got = 8'hxx;
      if (gotBytes.size() > n0 + 1) got = gotBytes[n0 + 1];
      checkOutput("rx_trio_byte1", got, 8'h62);
      got = 8'hxx;
      if (gotBytes.size() > n0 + 2) got = gotBytes[n0 + 2];
      checkOutput("rx_trio_byte2", got, 8'h0A);

      // Loopback: o_Received drives i_Start, o_Data drives i_Data
      seen = 1'b0;
      fork
         sendRxFrame(8'h61, 1'b1, 100);
         begin
            for (int k = 0; k < 12 * CPB; k++) begin
               @(posedge clock);
               #1;
               start = oRecv;
               din   = oData;
               if (oRecv === 1'b1) begin
                  seen = 1'b1;
                  recvCyc = cyc;
                  break;
               end
            end
            @(posedge clock);
            #1;
            start = 1'b0;
         end
      join
      checkOutput("loopback_pulse_seen", seen, 1'b1);
      waitBusyIdle();
      waitCycles(2);
      checkOutput("loopback_tx_latency", busyRiseCyc - recvCyc, 1);
      checkOutput("loopback_busy_len", lastBusyRun, 320);
      checkOutput("loopback_o_Data", oData, 8'h61);

      // Glitch shorter than half a bit
      sc0 = sampleCount;
      n0  = gotBytes.size();
      @(posedge clock);
      #1;
      s  = cyc;
      rx = 1'b0;
      spQ.push_back(s + SYNC + HALF);
      waitCycles(HALF / 2);
      rx = 1'b1;
      waitCycles(3 * CPB);
      checkOutput("glitch_sample_count", sampleCount - sc0, 1);
      checkOutput("glitch_no_receive", gotBytes.size() - n0, 0);

      // Framing error followed by a good frame
      n0  = gotBytes.size();
      sc0 = sampleCount;
      sendRxFrame(8'h55, 1'b0, 100);
      waitCycles(4);
      checkOutput("frame_err_no_receive", gotBytes.size() - n0, 0);
      checkOutput("frame_err_samples", sampleCount - sc0, 10);
      @(negedge clock);
      checkOutput("frame_err_data_held", oData, 8'h61);
      sendRxFrame(8'h33, 1'b1, 100);
      waitCycles(4);
      checkOutput("after_frame_err_count", gotBytes.size() - n0, 1);
      got = 8'hxx;
      if (gotBytes.size() > n0) got = gotBytes[n0];
      checkOutput("after_frame_err_byte", got, 8'h33);

      // Start request while busy is dropped
      r0 = busyRises;
      applyStimulus(8'hC3);
      waitCycles(3 * CPB);
      applyStimulus(8'h18);
      waitBusyIdle();
      waitCycles(2 * CPB);
      checkOutput("busy_start_ignored_frames", busyRises - r0, 1);
      checkOutput("busy_start_ignored_len", lastBusyRun, 320);

      // Random concurrent traffic, sender rate within +/-3%
      n0 = gotBytes.size();
      for (int it = 0; it < 10; it++) begin
         logic [7:0] rxByte;
         logic [7:0] txA;
         logic [7:0] txB;
         int pct;
         int d1;
         int d2;
         bit two;
         rxByte = 8'($urandom);
         txA    = 8'($urandom);
         txB    = 8'($urandom);
         pct    = 97 + int'($urandom_range(6));
         d1     = int'($urandom_range(100));
         d2     = int'($urandom_range(300));
         two    = 1'($urandom);
         fork
            sendRxFrame(rxByte, 1'b1, pct);
            begin
               waitCycles(d1);
               applyStimulus(txA);
               if (two) begin
                  waitCycles(d2);
                  applyStimulus(txB);
               end
            end
         join
         waitBusyIdle();
         waitCycles(3 + d1 % 7);
      end
      checkOutput("random_rx_count", gotBytes.size() - n0, 10);

      waitCycles(CPB);
      checkOutput("pending_rx_events", recvQ.size(), 0);
      checkOutput("pending_sample_events", spQ.size(), 0);

      // Reset in the middle of a transmit frame
      applyStimulus(8'h3C);
      waitCycles(50);
      doReset();
      @(negedge clock);
      checkOutput("midframe_reset_o_TX", oTx, 1'b1);
      checkOutput("midframe_reset_busy", busy, 1'b0);
      checkOutput("midframe_reset_o_Data", oData, 8'h00);
      waitCycles(2 * CPB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart.md
# uart

Full-duplex 8N1 UART transceiver: one transmitter and one receiver sharing a single system clock and a fixed, parameterised bit period. It sits between the FPGA fabric and the external serial pins. The host logic hands it bytes to send and receives a one-cycle strobe for every received byte. The nominal system clock is 80 MHz with CLKS_PER_BIT = 694, about 115200 baud.

## Interface
- CLKS_PER_BIT, default 694: system clocks per serial bit. Legal values are 4 or more. Half-bit is CLKS_PER_BIT >> 1.
- i_Clock  in  1  system clock. All logic is on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Start  in  1  transmit request. Sampled only when busy = 0.
- i_Data  in  8  byte to transmit. Captured in the cycle i_Start is accepted.
- o_TX  out  1  serial output. Idle level is high.
- i_RX  in  1  serial input. Asynchronous to i_Clock. Idle level is high.
- o_Received  out  1  one-cycle strobe: a valid byte is on o_Data.
- o_Data  out  8  last correctly received byte. Held until the next valid byte.
- busy  out  1  transmitter active.
- sample_point  out  1  one-cycle strobe marking each receiver mid-bit sample instant (debug).

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Reset values: o_TX = 1, busy = 0, o_Received = 0, o_Data = 0x00, sample_point = 0. Both FSMs return to IDLE.
- Reset asserted mid-frame aborts the frame immediately. o_TX returns high on the next edge.
- TX FSM states: IDLE → START → DATA (8 bits) → STOP → IDLE.
  - IDLE: when i_Start = 1, latch i_Data, set busy, enter START.
  - START, each DATA bit and STOP each last exactly CLKS_PER_BIT cycles. The bit index wraps 7 → STOP.
  - i_Start while busy = 1 is ignored. It is not queued.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on i_RX = 0, enter START.
  - START: after half-bit cycles, re-sample. If i_RX = 1 (glitch), return to IDLE. Otherwise enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles, shifting in LSB first.
  - STOP: sample one CLKS_PER_BIT after the last data bit.
    - Stop = 1: load o_Data and pulse o_Received for one cycle.
    - Stop = 0 (framing error): discard the byte, no pulse, wait for i_RX = 1, then IDLE.
  - After a good stop sample, return to IDLE immediately (mid stop bit), so back-to-back frames are received.
- sample_point pulses in the cycle of each START check, DATA sample and STOP sample: 10 pulses per good frame.
- TX and RX are fully independent and may run simultaneously. An external loopback (o_Received → i_Start, o_Data → i_Data) must echo bytes.

## Timing
- TX:
  - o_TX drops to 0 and busy rises on the edge after i_Start is accepted (1-cycle latency).
  - busy stays high for exactly 10 × CLKS_PER_BIT cycles and falls in the same cycle o_TX ends the stop bit.
  - A new i_Start is accepted in the first cycle busy = 0.
- RX:
  - Each data sample lands (k + 1.5) × CLKS_PER_BIT cycles after the detected falling edge, k = 0..7, plus synchroniser delay.
  - o_Received asserts the cycle after the stop sample, 9.5 × CLKS_PER_BIT cycles after the edge plus synchroniser delay.
  - o_Data changes in that same cycle.
- Counters are wide enough for CLKS_PER_BIT − 1 ($clog2). They count 0..CLKS_PER_BIT−1 and wrap to 0 on each bit boundary.
- Baud tolerance: a sender whose bit period is within ±3% of the nominal period must be received correctly.

## Configuration
- UART_RX_SYNC_EN defined: i_RX passes through a two-flop synchroniser (reset value 1) before the RX FSM. All RX timings gain 2 cycles of latency.
- Not defined: i_RX feeds the FSM directly. This is for benches and pre-synchronised inputs only.

## Test plan
- Reset: hold i_Reset for 1 cycle → o_TX = 1, busy = 0, o_Received = 0, o_Data = 0x00.
- RX 0x61, 0x62, 0x0A back-to-back, 8600 ns bits at 80 MHz → three single-cycle o_Received pulses with o_Data = 0x61, 0x62, 0x0A in order.
- TX 0xA5 with i_Start for 1 cycle → o_TX bits 0,1,0,1,0,0,1,0,1,1, each 694 cycles. busy is high for 6940 cycles.
- Loopback (o_Received drives i_Start) with RX 0x61 → o_TX re-emits 0x61, starting 1 cycle after the o_Received pulse.
- Glitch: i_RX low for 200 cycles, then high → no sample_point after the START check, no o_Received, RX back in IDLE.
- Framing error: frame 0x55 with stop bit 0 → no o_Received, o_Data unchanged. A following valid 0x33 is received correctly. i_Start during busy is ignored (no second frame).
